// File: rtl/drive_sequencer.sv
// drive_sequencer: top-level run controller for the motor path.
//
// Issues a latched start to the accelerator, passes the accelerator PWM through to the motor
// while ramping, then holds a fixed cruise duty for CRUISE_MS before stopping. Obstacles abort
// the run, and an acceleration watchdog forces a sticky FAULT if the ramp never completes.
// This block is the only driver of the motor PWM pin.
//
// Optional feature macro: SOFT_STOP_EN
//   defined   - a timed CRUISE->STOP drives half the cruise duty (integer divide) for the first
//               half of the stop hold, then 0; obstacle stops are always a hard 0.
//   undefined - STOP always drives motor_pwm = 0.
//
// Ports:
//   clk_1mhz           in   1 MHz system clock, all logic on the rising edge
//   reset              in   synchronous active-high reset
//   go                 in   run request; rising edge acted on only in IDLE
//   obstacle           in   level, high = obstacle present
//   accelerated        in   accelerator done flag
//   accelerator_active in   accelerator running flag (status only, not used for sequencing)
//   accel_pwm          in   accelerator PWM output
//   accel_start        out  start to accelerator, high throughout ACCEL
//   accel_reset        out  one-cycle pulse that re-arms the accelerator
//   motor_pwm          out  registered motor drive
//   state              out  IDLE=0, ACCEL=1, CRUISE=2, STOP=3, FAULT=4
//   busy               out  state is not IDLE
//   fault              out  state is FAULT
//
// US_PER_MS sets the number of clock cycles per millisecond tick (1000 at 1 MHz); it is only
// lowered to shorten simulation runs.

module drive_sequencer #(
    parameter int unsigned CRUISE_MS        = 2000,
    parameter int unsigned CRUISE_DUTY      = 75,
    parameter int unsigned ACCEL_TIMEOUT_MS = 1200,
    parameter int unsigned STOP_HOLD_MS     = 500,
    parameter int unsigned US_PER_MS        = 1000
) (
    input  logic       clk_1mhz,
    input  logic       reset,
    input  logic       go,
    input  logic       obstacle,
    input  logic       accelerated,
    input  logic       accelerator_active,
    input  logic       accel_pwm,
    output logic       accel_start,
    output logic       accel_reset,
    output logic       motor_pwm,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned PwmPeriod = 100;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAccel  = 3'd1,
        StCruise = 3'd2,
        StStop   = 3'd3,
        StFault  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] us_cnt_q, us_cnt_d;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [6:0]  pwm_cnt_q, pwm_cnt_d;
    logic        go_q;
    logic        accel_start_q, accel_start_d;
    logic        accel_reset_q, accel_reset_d;
    logic        motor_pwm_q, motor_pwm_d;

    logic        go_rise;
    logic        ms_tick;
    logic        leaving;
    logic        reset_req;
    logic        timed_stop;

    // Accelerator activity is reported for status only; sequencing never looks at it.
    logic        unused_accel_active;
    assign unused_accel_active = accelerator_active;

    assign go_rise = go & ~go_q;
    assign ms_tick = (us_cnt_q == 16'(US_PER_MS - 1));

`ifdef SOFT_STOP_EN
    // Set only when STOP was entered by the cruise timer, so obstacle stops stay hard.
    logic soft_q, soft_d;
`endif

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        reset_req  = 1'b0;
        timed_stop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_rise && !obstacle) begin
                    state_d = StAccel;
                end
            end
            StAccel: begin
                if (obstacle) begin
                    state_d = StStop;
                end else if (accelerated) begin
                    state_d = StCruise;
                end else if (ms_cnt_q == 16'(ACCEL_TIMEOUT_MS)) begin
                    state_d = StFault;
                end
                reset_req = (state_d != StAccel);
            end
            StCruise: begin
                if (obstacle) begin
                    state_d   = StStop;
                    reset_req = 1'b1;
                end else if (ms_cnt_q == 16'(CRUISE_MS)) begin
                    state_d    = StStop;
                    timed_stop = 1'b1;
                end
            end
            StStop: begin
                // Obstacle is deliberately ignored here; the hold always runs to completion.
                if (ms_cnt_q == 16'(STOP_HOLD_MS)) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign leaving = (state_d != state_q);

    // Timebase: all three counters restart from zero on every state change.
    always_comb begin
        us_cnt_d  = us_cnt_q;
        ms_cnt_d  = ms_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        if (leaving) begin
            us_cnt_d  = '0;
            ms_cnt_d  = '0;
            pwm_cnt_d = '0;
        end else begin
            us_cnt_d  = ms_tick ? '0 : us_cnt_q + 16'd1;
            ms_cnt_d  = ms_tick ? ms_cnt_q + 16'd1 : ms_cnt_q;
            pwm_cnt_d = (pwm_cnt_q == 7'(PwmPeriod - 1)) ? '0 : pwm_cnt_q + 7'd1;
        end
    end

`ifdef SOFT_STOP_EN
    always_comb begin
        soft_d = soft_q;
        if (leaving) begin
            soft_d = timed_stop;
        end
    end
`else
    logic unused_timed_stop;
    assign unused_timed_stop = timed_stop;
`endif

    // Registered outputs.
    always_comb begin
        accel_start_d = (state_d == StAccel);
        // Suppress back-to-back pulses, e.g. an obstacle on the first CRUISE cycle.
        accel_reset_d = reset_req & ~accel_reset_q;

        motor_pwm_d = 1'b0;
        unique case (state_q)
            StAccel:  motor_pwm_d = accel_pwm;
            StCruise: motor_pwm_d = (pwm_cnt_q < 7'(CRUISE_DUTY));
`ifdef SOFT_STOP_EN
            StStop:   motor_pwm_d = soft_q
                                  && (ms_cnt_q < 16'(STOP_HOLD_MS / 2))
                                  && (pwm_cnt_q < 7'(CRUISE_DUTY / 2));
`endif
            default:  motor_pwm_d = 1'b0;
        endcase
        // Any entry into a quiet state drives the pin low on the very next cycle.
        if (leaving && (state_d == StStop || state_d == StFault || state_d == StIdle)) begin
            motor_pwm_d = 1'b0;
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (reset) begin
            state_q       <= StIdle;
            us_cnt_q      <= '0;
            ms_cnt_q      <= '0;
            pwm_cnt_q     <= '0;
            go_q          <= 1'b0;
            accel_start_q <= 1'b0;
            accel_reset_q <= 1'b0;
            motor_pwm_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            go_q          <= go;
            accel_start_q <= accel_start_d;
            accel_reset_q <= accel_reset_d;
            motor_pwm_q   <= motor_pwm_d;
        end
    end

`ifdef SOFT_STOP_EN
    always_ff @(posedge clk_1mhz) begin
        if (reset) begin
            soft_q <= 1'b0;
        end else begin
            soft_q <= soft_d;
        end
    end
`endif

    assign accel_start = accel_start_q;
    assign accel_reset = accel_reset_q;
    assign motor_pwm   = motor_pwm_q;
    assign state       = state_q;
    assign busy        = (state_q != StIdle);
    assign fault       = (state_q == StFault);

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Top-level run controller for the motor path. It issues a latched start to the accelerator and passes the accelerator PWM through to the motor. After the ramp completes it holds a fixed cruise duty for a set time, then stops. Obstacle aborts and an acceleration watchdog are handled here; the motor PWM pin is driven only by this block.

Parameters:
CRUISE_MS, 2000, cruise duration in ms (1..65535)
CRUISE_DUTY, 75, cruise duty in percent of a 100 us PWM period (0..100)
ACCEL_TIMEOUT_MS, 1200, max ms in ACCEL without accelerated before FAULT
STOP_HOLD_MS, 500, ms held in STOP before returning to IDLE

Ports:
clk_1mhz  in  1  1 MHz system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
go  in  1  run request; rising edge sampled only in IDLE
obstacle  in  1  level; high = obstacle present
accelerated  in  1  accelerator done flag (latched by accelerator)
accelerator_active  in  1  accelerator running flag; status only
accel_pwm  in  1  accelerator PWM output
accel_start  out  1  start to accelerator; held high through ACCEL
accel_reset  out  1  one-cycle pulse that re-arms the accelerator
motor_pwm  out  1  registered motor drive
state  out  3  IDLE=0, ACCEL=1, CRUISE=2, STOP=3, FAULT=4
busy  out  1  high when state is not IDLE
fault  out  1  high in FAULT

Behaviour:
- Reset: synchronous, active-high. All outputs 0, state=IDLE, all counters 0, and the go edge register is set to 0. Reset mid-operation takes effect on the next edge from any state.
- Timebase: us_cnt runs 0..999; ms_tick fires when us_cnt==999, and ms_cnt (16 bit) increments on ms_tick. A separate pwm_cnt runs 0..99 and wraps. All three counters clear on every state transition.
- Go edge detect: go_q <= go; go_rise = go & ~go_q. A go held high yields one run only. go is ignored outside IDLE.
- IDLE: motor_pwm=0, accel_start=0.
  - go_rise & ~obstacle -> ACCEL; accel_start goes to 1 on the same edge.
  - go_rise & obstacle -> stay IDLE.
- ACCEL: accel_start=1; motor_pwm <= accel_pwm (1-cycle latency). Exit priority, highest first:
  - obstacle -> STOP
  - accelerated -> CRUISE
  - ms_cnt==ACCEL_TIMEOUT_MS -> FAULT
  - Every exit from ACCEL: accel_start<=0 and accel_reset<=1 for exactly one cycle.
- CRUISE: motor_pwm <= (pwm_cnt < CRUISE_DUTY); CRUISE_DUTY=0 gives constant 0, CRUISE_DUTY=100 gives constant 1. Exits:
  - obstacle -> STOP, with accel_reset pulsed for one cycle.
  - ms_cnt==CRUISE_MS -> STOP, no accel_reset pulse.
  - If both occur in the same cycle, take the obstacle path.
- STOP: motor_pwm=0 (see optional feature). When ms_cnt==STOP_HOLD_MS -> IDLE. Obstacle in STOP is ignored; the hold continues.
- FAULT: motor_pwm=0, fault=1, accel_start=0. Sticky; only reset exits. go is ignored.
- motor_pwm is 0 on the cycle after any transition into STOP, FAULT or IDLE.
- accel_reset is never high for two consecutive cycles. accelerator_active is not used for sequencing.

Optional Feature:
SOFT_STOP_EN
- Defined: a timed CRUISE->STOP transition drives motor_pwm at duty CRUISE_DUTY/2 (integer divide) while ms_cnt < STOP_HOLD_MS/2, then 0 for the rest of STOP. Obstacle-triggered STOP is always a hard 0.
- Undefined: STOP always drives motor_pwm=0.

Test Plan:
1. Reset, then go pulse; bench model asserts accelerated at 1000 ms -> accel_start=1 and state=1 on the cycle after go, motor_pwm follows accel_pwm delayed by 1 cycle; on the cycle after accelerated, state=2, accel_start=0, accel_reset high for exactly 1 cycle.
2. Defaults in CRUISE -> motor_pwm high for 75 of every 100 cycles; after 2000 ms state=3 and motor_pwm=0; after a further 500 ms state=0 and busy=0.
3. Obstacle at 300 ms into CRUISE -> next cycle state=3, motor_pwm=0, accel_reset 1-cycle pulse. Repeat in ACCEL with obstacle and accelerated high in the same cycle -> state=3, not 2.
4. accelerated held 0 -> at 1200 ms state=4, fault=1, accel_reset pulse; later go edges leave state=4; reset -> state=0, fault=0.
5. go held high across a full run -> exactly one ACCEL entry. go edge with obstacle=1 in IDLE -> state stays 0, accel_start=0.
6. Reset asserted mid-CRUISE -> next edge all outputs 0, state=0. With SOFT_STOP_EN: timed STOP gives 37 high cycles per 100 for 250 ms, then 0.
